// File: rtl/viterbi_feeder_pkg.sv
// Shared types for the Viterbi frame feeder.
//   launch_state_e : launcher FSM states
//   bank_state_e   : per-bank fill status
//   bank_sel_w()   : bank index width for a given bank count (at least 1 bit)
package viterbi_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } launch_state_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } bank_state_e;

    function automatic int bank_sel_w(input int num_buf);
        return (num_buf > 1) ? $clog2(num_buf) : 1;
    endfunction

    localparam int NUM_BUF_DEF = 2;
    localparam int BANK_SEL_W  = bank_sel_w(NUM_BUF_DEF);

endpackage

// File: rtl/viterbi_frame_feeder_if.sv
// Softbit word stream (valid/ready handshake).
//   master : drives valid/data/last, receives ready
//   slave  : receives valid/data/last, drives ready
interface viterbi_frame_feeder_if #(
    parameter int SB_W = 24
);
    logic            valid;
    logic            ready;
    logic [SB_W-1:0] data;
    logic            last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/viterbi_feeder_bank_ctrl.sv
// Bank bookkeeping for the feeder: one EMPTY/FULL flag per bank plus the
// fill and launch pointers. Banks are filled and launched in the same
// circular order, so the two pointers form a FIFO of bank indices.
//   close_i : the fill bank has received its last word -> FULL, advance
//   free_i  : the launch bank has been decoded -> EMPTY, advance
//   clr_i   : synchronous return to the reset state
module viterbi_feeder_bank_ctrl
    import viterbi_feeder_pkg::*;
#(
    parameter int NUM_BUF = 2,
    localparam int SEL_W  = bank_sel_w(NUM_BUF)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             close_i,
    input  logic             free_i,
    output logic [SEL_W-1:0] fill_bank_o,
    output logic [SEL_W-1:0] launch_bank_o,
    output logic             fill_empty_o,
    output logic             launch_full_o,
    output logic             all_empty_o
);

    bank_state_e      status_q [NUM_BUF];
    bank_state_e      status_d [NUM_BUF];
    logic [SEL_W-1:0] fill_q, fill_d;
    logic [SEL_W-1:0] launch_q, launch_d;

    // Close and free never address the same bank: close needs an EMPTY fill
    // bank, free needs a FULL launch bank.
    always_comb begin
        status_d = status_q;
        fill_d   = fill_q;
        launch_d = launch_q;
        if (clr_i) begin
            for (int i = 0; i < NUM_BUF; i++) status_d[i] = EMPTY;
            fill_d   = '0;
            launch_d = '0;
        end else begin
            if (close_i) begin
                status_d[fill_q] = FULL;
                fill_d           = fill_q + 1'b1;
            end
            if (free_i) begin
                status_d[launch_q] = EMPTY;
                launch_d           = launch_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_BUF; i++) status_q[i] <= EMPTY;
            fill_q   <= '0;
            launch_q <= '0;
        end else begin
            status_q <= status_d;
            fill_q   <= fill_d;
            launch_q <= launch_d;
        end
    end

    always_comb begin
        all_empty_o = 1'b1;
        for (int i = 0; i < NUM_BUF; i++) begin
            if (status_q[i] != EMPTY) all_empty_o = 1'b0;
        end
    end

    assign fill_bank_o   = fill_q;
    assign launch_bank_o = launch_q;
    assign fill_empty_o  = (status_q[fill_q] == EMPTY);
    assign launch_full_o = (status_q[launch_q] == FULL);

endmodule

// File: rtl/viterbi_frame_feeder.sv
// Multi-bank softbit loader in front of viterbi_core. Each frame from the
// input stream is written into its own bank of the source SRAM; full banks
// are launched on the core in order and freed on frame_done.
//   in_s                 : softbit word stream (slave side)
//   sram_*               : source SRAM port, shared with core reads
//   core_src_rd_i/addr_i : core read request (has priority over writes)
//   core_frame_start_o   : one-cycle launch pulse, with bank base address
//   core_frame_done_i    : core completion pulse
//   frames_done_o        : completed-frame count (wraps)
//   len_err_o            : sticky frame-length error
//   idle_o               : nothing buffered and launcher idle
//
// Launcher states:
//   state | meaning
//   IDLE  | no frame in the core; launch when the oldest bank is FULL
//   START | core_frame_start_o high for this one cycle
//   WAIT  | core decoding; frame_done frees the bank
module viterbi_frame_feeder
    import viterbi_feeder_pkg::*;
#(
    parameter int SB_W       = 24,
    parameter int SRC_ADDR_W = 12,
    parameter int BANK_AW    = 8,
    parameter int NUM_BUF    = 2,
    parameter int LEN_W      = 12,
    parameter int CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  enable_i,
    input  logic [LEN_W-1:0]      frame_words_i,
    viterbi_frame_feeder_if.slave in_s,
    output logic                  sram_wr_o,
    output logic                  sram_rd_o,
    output logic [SRC_ADDR_W-1:0] sram_addr_o,
    output logic [SB_W-1:0]       sram_wdata_o,
    input  logic                  core_src_rd_i,
    input  logic [SRC_ADDR_W-1:0] core_src_addr_i,
    output logic                  core_frame_start_o,
    output logic [SRC_ADDR_W-1:0] core_src_start_addr_o,
    input  logic                  core_frame_done_i,
    output logic [CNT_W-1:0]      frames_done_o,
    output logic                  len_err_o,
    output logic                  idle_o
);

    localparam int SEL_W = bank_sel_w(NUM_BUF);
    localparam int CMP_W = (LEN_W > BANK_AW + 1) ? LEN_W : BANK_AW + 1;
    localparam int CAP_I = 1 << BANK_AW;
    localparam logic [CMP_W-1:0] CAP = CMP_W'(CAP_I);

    logic [SEL_W-1:0]      fill_bank, launch_bank;
    logic                  fill_empty, launch_full, all_empty;
    logic                  accept, close, free, err_now;
    logic                  hit_len, hit_cap, bad_len;
    logic [CMP_W-1:0]      cnt, eff_len;

    logic [BANK_AW-1:0]    wptr_q, wptr_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic                  len_err_q, len_err_d;
    launch_state_e         state_q, state_d;
    logic                  start_q, start_d;
    logic [SRC_ADDR_W-1:0] start_addr_q, start_addr_d;
    logic [CNT_W-1:0]      done_cnt_q, done_cnt_d;

    viterbi_feeder_bank_ctrl #(.NUM_BUF(NUM_BUF)) u_bank_ctrl (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .clr_i         (clr_i),
        .close_i       (close),
        .free_i        (free),
        .fill_bank_o   (fill_bank),
        .launch_bank_o (launch_bank),
        .fill_empty_o  (fill_empty),
        .launch_full_o (launch_full),
        .all_empty_o   (all_empty)
    );

    assign in_s.ready = enable_i && !clr_i && !core_src_rd_i && fill_empty;
    assign accept     = in_s.valid && in_s.ready;

    // Frame length is latched on the first word of a bank; that first word
    // must already be checked against the live input.
    assign eff_len = (wptr_q == '0) ? CMP_W'(frame_words_i) : CMP_W'(len_q);
    assign cnt     = CMP_W'(wptr_q) + CMP_W'(1);
    assign hit_len = (cnt == eff_len);
    assign hit_cap = (cnt == CAP);
    assign bad_len = (eff_len == '0) || (eff_len > CAP);
    assign close   = accept && (in_s.last || hit_len || hit_cap);
    assign err_now = accept && ((in_s.last && !hit_len) ||
                                ((hit_len || hit_cap) && !in_s.last) ||
                                bad_len);
    assign free    = (state_q == WAIT) && core_frame_done_i && !clr_i;

    // Core reads own the port; loader writes only ever happen when ready,
    // which already excludes read cycles.
    always_comb begin
        sram_wr_o    = 1'b0;
        sram_rd_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        if (core_src_rd_i) begin
            sram_rd_o   = 1'b1;
            sram_addr_o = core_src_addr_i;
        end else if (accept) begin
            sram_wr_o    = 1'b1;
            sram_addr_o  = SRC_ADDR_W'({fill_bank, wptr_q});
            sram_wdata_o = in_s.data;
        end
    end

    always_comb begin
        wptr_d    = wptr_q;
        len_d     = len_q;
        len_err_d = len_err_q;
        if (clr_i) begin
            wptr_d    = '0;
            len_d     = '0;
            len_err_d = 1'b0;
        end else if (accept) begin
            if (wptr_q == '0) len_d = frame_words_i;
            wptr_d = close ? '0 : wptr_q + 1'b1;
            if (err_now) len_err_d = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        start_d      = 1'b0;
        start_addr_d = start_addr_q;
        done_cnt_d   = done_cnt_q;
        if (clr_i) begin
            state_d      = IDLE;
            start_addr_d = '0;
            done_cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable_i && launch_full) begin
                        state_d      = START;
                        start_d      = 1'b1;
                        start_addr_d = SRC_ADDR_W'(launch_bank) << BANK_AW;
                    end
                end
                START: state_d = WAIT;
                WAIT: begin
                    if (core_frame_done_i) begin
                        state_d    = IDLE;
                        done_cnt_d = done_cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q       <= '0;
            len_q        <= '0;
            len_err_q    <= 1'b0;
            state_q      <= IDLE;
            start_q      <= 1'b0;
            start_addr_q <= '0;
            done_cnt_q   <= '0;
        end else begin
            wptr_q       <= wptr_d;
            len_q        <= len_d;
            len_err_q    <= len_err_d;
            state_q      <= state_d;
            start_q      <= start_d;
            start_addr_q <= start_addr_d;
            done_cnt_q   <= done_cnt_d;
        end
    end

    assign core_frame_start_o    = start_q;
    assign core_src_start_addr_o = start_addr_q;
    assign frames_done_o         = done_cnt_q;
    assign len_err_o             = len_err_q;
    assign idle_o                = all_empty && (state_q == IDLE) && (wptr_q == '0);

endmodule

// File: tb/tb_viterbi_frame_feeder.sv
// Directed bench for viterbi_frame_feeder: a 2-bank default instance and a
// 4-bank / 64-word instance share stimulus; sel picks the active one.
module tb_viterbi_frame_feeder;

    localparam int STALL_MAX = 2000;

    typedef struct packed {
        logic [11:0] addr;
        logic [23:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst, clr, en, sel;
    logic [11:0] fw;
    logic        s_valid, s_last;
    logic [23:0] s_data;
    logic        core_rd;
    logic [11:0] core_addr;
    logic        model_done, man_done, core_auto, rd_tog;
    logic        core_done;
    int          core_lat, mcnt;

    int n_cmp = 0;
    int n_bad = 0;
    int tb_fill, cap, nbuf;
    wr_t         wq[$];
    logic [11:0] sq[$];

    logic        wr2, rd2, st2, err2, idle2, wr4, rd4, st4, err4, idle4;
    logic [11:0] addr2, saddr2, addr4, saddr4;
    logic [23:0] wdata2, wdata4;
    logic [15:0] fd2, fd4;

    logic        m_rdy, m_wr, m_rd, m_start, m_err, m_idle;
    logic [11:0] m_addr, m_saddr;
    logic [23:0] m_wdata;
    logic [15:0] m_fd;

    viterbi_frame_feeder_if #(.SB_W(24)) if2 ();
    viterbi_frame_feeder_if #(.SB_W(24)) if4 ();

    assign if2.valid = s_valid & ~sel;
    assign if4.valid = s_valid & sel;
    assign if2.data  = s_data;
    assign if4.data  = s_data;
    assign if2.last  = s_last;
    assign if4.last  = s_last;
    assign core_done = model_done | man_done;

    viterbi_frame_feeder dut2 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .enable_i(en), .frame_words_i(fw),
        .in_s(if2), .sram_wr_o(wr2), .sram_rd_o(rd2), .sram_addr_o(addr2),
        .sram_wdata_o(wdata2), .core_src_rd_i(core_rd), .core_src_addr_i(core_addr),
        .core_frame_start_o(st2), .core_src_start_addr_o(saddr2),
        .core_frame_done_i(core_done), .frames_done_o(fd2), .len_err_o(err2),
        .idle_o(idle2)
    );

    viterbi_frame_feeder #(.NUM_BUF(4), .BANK_AW(6)) dut4 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .enable_i(en), .frame_words_i(fw),
        .in_s(if4), .sram_wr_o(wr4), .sram_rd_o(rd4), .sram_addr_o(addr4),
        .sram_wdata_o(wdata4), .core_src_rd_i(core_rd), .core_src_addr_i(core_addr),
        .core_frame_start_o(st4), .core_src_start_addr_o(saddr4),
        .core_frame_done_i(core_done), .frames_done_o(fd4), .len_err_o(err4),
        .idle_o(idle4)
    );

    assign m_rdy   = sel ? if4.ready : if2.ready;
    assign m_wr    = sel ? wr4 : wr2;
    assign m_rd    = sel ? rd4 : rd2;
    assign m_addr  = sel ? addr4 : addr2;
    assign m_wdata = sel ? wdata4 : wdata2;
    assign m_start = sel ? st4 : st2;
    assign m_saddr = sel ? saddr4 : saddr2;
    assign m_fd    = sel ? fd4 : fd2;
    assign m_err   = sel ? err4 : err2;
    assign m_idle  = sel ? idle4 : idle2;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Core model: done pulse core_lat cycles after each observed launch.
    always @(negedge clk) begin
        model_done = 1'b0;
        if (rst) mcnt = 0;
        else if (core_auto && m_start) mcnt = core_lat;
        else if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) model_done = 1'b1;
        end
    end

    // Core read traffic: every other cycle while rd_tog is set.
    always @(negedge clk) begin
        if (rd_tog) begin
            core_rd   = ~core_rd;
            core_addr = 12'($urandom);
        end else begin
            core_rd   = 1'b0;
            core_addr = '0;
        end
    end

    // Scoreboard monitor for SRAM writes, launches and read pass-through.
    always begin
        wr_t         ew;
        logic [11:0] es;
        @(negedge clk);
        #2;
        if (!rst) begin
            if (m_wr) begin
                if (wq.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    ew = wq.pop_front();
                    chk("wr_addr", 32'(m_addr), 32'(ew.addr));
                    chk("wr_data", 32'(m_wdata), 32'(ew.data));
                end
            end
            if (m_start) begin
                if (sq.size() == 0) chk("start_unexpected", 1, 0);
                else begin
                    es = sq.pop_front();
                    chk("start_addr", 32'(m_saddr), 32'(es));
                end
            end
            if (core_rd) begin
                chk("rd_ready_low", 32'(m_rdy), 0);
                chk("rd_en", 32'(m_rd), 1);
                chk("rd_no_wr", 32'(m_wr), 0);
                chk("rd_addr", 32'(m_addr), 32'(core_addr));
            end
        end
    end

    task automatic send_frame(input int n, input int last_at, input int fwords);
        int   base, k;
        logic acc;
        base = tb_fill * cap;
        fw   = 12'(fwords);
        sq.push_back(12'(base));
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = 24'($urandom);
            s_last  = (i == last_at);
            wq.push_back('{addr: 12'(base + i), data: s_data});
            k = 0;
            do begin
                #1;
                acc = m_rdy;
                @(negedge clk);
                k++;
            end while (!acc && k < STALL_MAX);
            if (!acc) begin
                chk("accept_timeout", 0, 1);
                break;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        tb_fill = (tb_fill + 1) % nbuf;
    endtask

    task automatic wait_frames(input int target, input int bound);
        int k = 0;
        while (m_fd != 16'(target) && k < bound) begin
            @(negedge clk);
            k++;
        end
        chk("frames_done", 32'(m_fd), 32'(target));
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr     = 1'b0;
        tb_fill = 0;
    endtask

    initial begin
        int k;
        rst = 1'b1; clr = 1'b0; en = 1'b0; sel = 1'b0; fw = '0;
        s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        man_done = 1'b0; core_auto = 1'b1; rd_tog = 1'b0; core_lat = 500;
        tb_fill = 0; cap = 256; nbuf = 2;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_idle", 32'(m_idle), 1);
        chk("rst_ready_dis", 32'(m_rdy), 0);
        chk("rst_frames", 32'(m_fd), 0);
        chk("rst_len_err", 32'(m_err), 0);
        chk("rst_start", 32'(m_start), 0);
        chk("rst_start_addr", 32'(m_saddr), 0);
        chk("rst_wr", 32'(m_wr), 0);
        chk("rst_addr", 32'(m_addr), 0);
        en = 1'b1;
        #1;
        chk("ready_enabled", 32'(m_rdy), 1);

        // One 192-word frame
        send_frame(192, 191, 192);
        wait_frames(1, 2000);
        chk("t1_len_err", 32'(m_err), 0);
        chk("t1_idle", 32'(m_idle), 1);

        // Three back-to-back frames; the third waits for bank 0 to free
        do_clr();
        chk("clr_idle", 32'(m_idle), 1);
        chk("clr_frames", 32'(m_fd), 0);
        send_frame(192, 191, 192);
        send_frame(192, 191, 192);
        chk("t2_stall_ready", 32'(m_rdy), 0);
        chk("t2_stall_frames", 32'(m_fd), 0);
        send_frame(192, 191, 192);
        wait_frames(3, 3000);

        // Streaming with interleaved core reads
        core_lat = 100;
        rd_tog   = 1'b1;
        send_frame(192, 191, 192);
        rd_tog   = 1'b0;
        wait_frames(4, 1000);
        chk("t3_len_err", 32'(m_err), 0);

        // Early in_last: closes after 101 words, flags, still launches
        send_frame(101, 100, 192);
        chk("t4_len_err", 32'(m_err), 1);
        wait_frames(5, 1000);
        chk("t4_idle", 32'(m_idle), 1);

        // Clear during WAIT, then a late done
        do_clr();
        chk("clr_err_cleared", 32'(m_err), 0);
        core_auto = 1'b0;
        send_frame(20, 19, 20);
        k = 0;
        while (!m_start && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("t7_launched", 32'(m_start), 1);
        @(negedge clk);
        chk("t7_busy", 32'(m_idle), 0);
        do_clr();
        chk("t7_idle_after_clr", 32'(m_idle), 1);
        chk("t7_frames_after_clr", 32'(m_fd), 0);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("t7_late_done_frames", 32'(m_fd), 0);
        chk("t7_late_done_idle", 32'(m_idle), 1);
        core_auto = 1'b1;

        // Full-capacity frame, then closure by count without in_last
        send_frame(256, 255, 256);
        chk("t5_len_err", 32'(m_err), 0);
        wait_frames(1, 1000);
        send_frame(10, -1, 10);
        chk("t6_len_err", 32'(m_err), 1);
        wait_frames(2, 1000);

        // Four 64-word banks queued, then bank 0 refills
        repeat (3) @(negedge clk);
        sel = 1'b1; cap = 64; nbuf = 4; tb_fill = 0; core_lat = 400;
        @(negedge clk);
        chk("t8_idle", 32'(m_idle), 1);
        for (int f = 0; f < 4; f++) send_frame(64, 63, 64);
        chk("t8_all_full_ready", 32'(m_rdy), 0);
        chk("t8_frames", 32'(m_fd), 0);
        send_frame(64, 63, 64);
        wait_frames(5, 4000);
        chk("t8_len_err", 32'(m_err), 0);
        chk("t8_idle_end", 32'(m_idle), 1);

        repeat (5) @(negedge clk);
        chk("wr_queue_drained", 32'(wq.size()), 0);
        chk("start_queue_drained", 32'(sq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
